// File: rtl/i2c_slave_rx.sv
// i2c_slave_rx: oversampled I2C write responder. ACKs [SLAVE_ADDR+W, SUB, DATA...] and strobes each data byte.
// Define I2C_SLAVE_RX_FILTER_EN to add a 3-sample majority glitch filter on SCL and SDA.
module i2c_slave_rx #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h1A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       I2C_SCLK,
  inout  wire        I2C_SDAT,
  output logic [7:0] REG_ADDR,
  output logic [7:0] REG_DATA,
  output logic       REG_WE,
  output logic       BUSY,
  output logic       NACKED
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, DATA, DATA_ACK, IGNORE
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_f, sda_f;
  logic                   scl_d, sda_d;
  logic [7:0]             shreg;
  logic [3:0]             bit_cnt;
  logic                   sda_low;

  assign I2C_SDAT = sda_low ? 1'b0 : 1'bz;

  // Synchroniser stage: idle bus level is high, so reset to ones to avoid false edges.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], I2C_SCLK};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], I2C_SDAT};
    end
  end

`ifdef I2C_SLAVE_RX_FILTER_EN
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic [1:0] scl_win, sda_win;

  // Filter stage: a level must persist for two samples to pass.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      scl_win <= '1;
      sda_win <= '1;
      scl_f   <= 1'b1;
      sda_f   <= 1'b1;
    end else begin
      scl_win <= {scl_win[0], scl_sync[SYNC_STAGES-1]};
      sda_win <= {sda_win[0], sda_sync[SYNC_STAGES-1]};
      scl_f   <= maj3(scl_win[1], scl_win[0], scl_sync[SYNC_STAGES-1]);
      sda_f   <= maj3(sda_win[1], sda_win[0], sda_sync[SYNC_STAGES-1]);
    end
  end
`else
  assign scl_f = scl_sync[SYNC_STAGES-1];
  assign sda_f = sda_sync[SYNC_STAGES-1];
`endif

  // Edge-detect stage.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_f;
      sda_d <= sda_f;
    end
  end

  logic scl_rise, scl_fall, start_ev, stop_ev, shifting, addr_hit;
  assign scl_rise = scl_f & ~scl_d;
  assign scl_fall = ~scl_f & scl_d;
  assign start_ev = scl_f & scl_d & sda_d & ~sda_f;
  assign stop_ev  = scl_f & scl_d & ~sda_d & sda_f;
  assign shifting = (state == ADDR) || (state == SUB) || (state == DATA);
  assign addr_hit = (shreg[7:1] == SLAVE_ADDR);

  // Protocol FSM: START/STOP take priority in every state and drop any ACK being driven.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state    <= IDLE;
      bit_cnt  <= 4'd0;
      shreg    <= 8'd0;
      sda_low  <= 1'b0;
      REG_ADDR <= 8'd0;
      REG_DATA <= 8'd0;
      REG_WE   <= 1'b0;
      BUSY     <= 1'b0;
      NACKED   <= 1'b0;
    end else begin
      REG_WE <= 1'b0;
      if (start_ev) begin
        state   <= ADDR;
        bit_cnt <= 4'd0;
        NACKED  <= 1'b0;
        sda_low <= 1'b0;
      end else if (stop_ev) begin
        state   <= IDLE;
        sda_low <= 1'b0;
        BUSY    <= 1'b0;
      end else begin
        if (scl_rise && shifting && bit_cnt != 4'd8) begin
          shreg   <= {shreg[6:0], sda_f};
          bit_cnt <= bit_cnt + 4'd1;
        end
        if (scl_fall) begin
          case (state)
            ADDR: if (bit_cnt == 4'd8) begin
              if (addr_hit && !shreg[0]) begin
                state   <= ADDR_ACK;
                sda_low <= 1'b1;
                BUSY    <= 1'b1;
              end else begin
                state <= IGNORE;
                if (addr_hit || BUSY) NACKED <= 1'b1;
              end
            end
            ADDR_ACK: begin
              sda_low <= 1'b0;
              bit_cnt <= 4'd0;
              state   <= SUB;
            end
            SUB: if (bit_cnt == 4'd8) begin
              sda_low <= 1'b1;
              state   <= SUB_ACK;
            end
            SUB_ACK: begin
              sda_low  <= 1'b0;
              REG_ADDR <= shreg;
              bit_cnt  <= 4'd0;
              state    <= DATA;
            end
            DATA: if (bit_cnt == 4'd8) begin
              REG_DATA <= shreg;
              REG_WE   <= 1'b1;
              sda_low  <= 1'b1;
              state    <= DATA_ACK;
            end
            DATA_ACK: begin
              sda_low  <= 1'b0;
              REG_ADDR <= REG_ADDR + 8'd1;
              bit_cnt  <= 4'd0;
              state    <= DATA;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Bench for i2c_slave_rx: bit-banged I2C master, scoreboard of expected register writes.
module tb_i2c_slave_rx;
  localparam int Q = 100;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b0;
  logic       scl = 1'b1;
  logic       m_sda_low = 1'b0;
  wire        sda_bus;
  logic [7:0] REG_ADDR, REG_DATA;
  logic       REG_WE, BUSY, NACKED;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  i2c_slave_rx #(.SLAVE_ADDR(7'h1A), .SYNC_STAGES(2)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .I2C_SCLK(scl), .I2C_SDAT(sda_bus),
    .REG_ADDR(REG_ADDR), .REG_DATA(REG_DATA), .REG_WE(REG_WE),
    .BUSY(BUSY), .NACKED(NACKED)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Write monitor: every strobe must match the head of the scoreboard.
  logic [7:0] prev_addr = 8'd0;
  logic       prev_we = 1'b0;
  always @(negedge CLOCK) begin : mon
    logic [15:0] e;
    if (REG_WE === 1'b1) begin
      check_eq("we_expected", 32'(exp_q.size() != 0), 32'd1);
      check_eq("we_pulse_single", 32'(prev_we), 32'd0);
      check_eq("we_addr_stable", 32'(REG_ADDR), 32'(prev_addr));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("we_addr", 32'(REG_ADDR), 32'(e[15:8]));
        check_eq("we_data", 32'(REG_DATA), 32'(e[7:0]));
      end
    end
    prev_addr = REG_ADDR;
    prev_we   = REG_WE;
  end

  task automatic bit_out(input logic b);
    m_sda_low = !b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) bit_out(v[3'(7 - i)]);
  endtask

  task automatic ack_clock(output logic a);
    m_sda_low = 1'b0; #Q; scl = 1'b1; #Q; a = sda_bus; #Q; scl = 1'b0; #Q;
  endtask

  task automatic send_byte(input logic [7:0] v, input logic exp_ack, input string tag);
    logic a;
    send_bits(v, 8);
    ack_clock(a);
    check_eq(tag, 32'(a), 32'(exp_ack));
  endtask

  task automatic i2c_start;
    if (!scl) begin m_sda_low = 1'b0; #Q; scl = 1'b1; #Q; end
    m_sda_low = 1'b1; #Q; scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop;
    m_sda_low = 1'b1; #Q; scl = 1'b1; #Q; m_sda_low = 1'b0; #(2*Q);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic a;
    #50;
    check_eq("rst_addr", 32'(REG_ADDR), 32'd0);
    check_eq("rst_data", 32'(REG_DATA), 32'd0);
    check_eq("rst_we", 32'(REG_WE), 32'd0);
    check_eq("rst_busy", 32'(BUSY), 32'd0);
    check_eq("rst_nacked", 32'(NACKED), 32'd0);
    check_eq("rst_sda", 32'(sda_bus), 32'd1);
    RESET = 1'b1;
    #(2*Q);

    // Single write.
    i2c_start;
    send_byte(8'h34, 1'b0, "t1_addr_ack");
    check_eq("t1_busy_on", 32'(BUSY), 32'd1);
    exp_q.push_back({8'h0A, 8'h5C});
    send_byte(8'h0A, 1'b0, "t1_sub_ack");
    send_byte(8'h5C, 1'b0, "t1_data_ack");
    i2c_stop;
    check_eq("t1_busy_off", 32'(BUSY), 32'd0);
    check_eq("t1_addr_after", 32'(REG_ADDR), 32'h0B);

    // Burst with sub-address wrap.
    i2c_start;
    send_byte(8'h34, 1'b0, "t2_addr_ack");
    send_byte(8'hFE, 1'b0, "t2_sub_ack");
    exp_q.push_back({8'hFE, 8'h11});
    exp_q.push_back({8'hFF, 8'h22});
    exp_q.push_back({8'h00, 8'h33});
    send_byte(8'h11, 1'b0, "t2_d0_ack");
    send_byte(8'h22, 1'b0, "t2_d1_ack");
    send_byte(8'h33, 1'b0, "t2_d2_ack");
    i2c_stop;
    check_eq("t2_addr_wrap", 32'(REG_ADDR), 32'h01);

    // Foreign address.
    i2c_start;
    send_byte(8'hA0, 1'b1, "t3_foreign_nack");
    check_eq("t3_busy", 32'(BUSY), 32'd0);
    check_eq("t3_nacked", 32'(NACKED), 32'd0);
    send_byte(8'h12, 1'b1, "t3_data_nack");
    i2c_stop;

    // Read request, then repeated START with a write.
    i2c_start;
    send_byte(8'h35, 1'b1, "t4_read_nack");
    check_eq("t4_nacked_set", 32'(NACKED), 32'd1);
    check_eq("t4_busy", 32'(BUSY), 32'd0);
    i2c_start;
    check_eq("t4_nacked_clr", 32'(NACKED), 32'd0);
    send_byte(8'h34, 1'b0, "t4_addr_ack");
    send_byte(8'h10, 1'b0, "t4_sub_ack");
    exp_q.push_back({8'h10, 8'h77});
    send_byte(8'h77, 1'b0, "t4_data_ack");
    i2c_stop;

    // Partial data byte aborted by STOP, then a fresh write.
    i2c_start;
    send_byte(8'h34, 1'b0, "t5_addr_ack");
    send_byte(8'h01, 1'b0, "t5_sub_ack");
    send_bits(8'hF0, 4);
    i2c_stop;
    check_eq("t5_sub_kept", 32'(REG_ADDR), 32'h01);
    check_eq("t5_busy_off", 32'(BUSY), 32'd0);
    i2c_start;
    send_byte(8'h34, 1'b0, "t5b_addr_ack");
    send_byte(8'h01, 1'b0, "t5b_sub_ack");
    exp_q.push_back({8'h01, 8'hA5});
    send_byte(8'hA5, 1'b0, "t5b_data_ack");
    i2c_stop;

    // Reset while the sub-address ACK is driven.
    i2c_start;
    send_byte(8'h34, 1'b0, "t6_addr_ack");
    send_bits(8'h42, 8);
    m_sda_low = 1'b0;
    #10;
    check_eq("t6_ack_driven", 32'(sda_bus), 32'd0);
    RESET = 1'b0;
    #1;
    check_eq("t6_sda_released", 32'(sda_bus), 32'd1);
    #9;
    check_eq("t6_rst_addr", 32'(REG_ADDR), 32'd0);
    check_eq("t6_rst_data", 32'(REG_DATA), 32'd0);
    check_eq("t6_rst_busy", 32'(BUSY), 32'd0);
    check_eq("t6_rst_nacked", 32'(NACKED), 32'd0);
    check_eq("t6_rst_we", 32'(REG_WE), 32'd0);
    #20;
    RESET = 1'b1;
    ack_clock(a);
    check_eq("t6_ack_after_rst", 32'(a), 32'd1);
    send_byte(8'h99, 1'b1, "t6_ignored_nack");
    check_eq("t6_busy_idle", 32'(BUSY), 32'd0);
    i2c_stop;
    i2c_start;
    send_byte(8'h34, 1'b0, "t6b_addr_ack");
    send_byte(8'h05, 1'b0, "t6b_sub_ack");
    exp_q.push_back({8'h05, 8'h3C});
    send_byte(8'h3C, 1'b0, "t6b_data_ack");
    i2c_stop;
    check_eq("t6b_addr_after", 32'(REG_ADDR), 32'h06);

    #(2*Q);
    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
